// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the control-unit sequencer.
//   state_t     - 3-bit FSM state encoding, also exported on the debug port
//   *_BIT       - bit positions of the decoder's one-hot instruction vector
//   INSTR_W     - width of the instruction vector
//   TMO_W       - width of the memory-ack timeout counter (limit 1..255)
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC_ADD = 3'd3,
    ST_EXEC_JMP = 3'd4,
    ST_LOAD     = 3'd5,
    ST_HALT     = 3'd6
  } state_t;

  localparam int ADD_BIT  = 0;
  localparam int JUMP_BIT = 1;
  localparam int LOAD_BIT = 2;
  localparam int HALT_BIT = 3;

  localparam int INSTR_W = 4;
  localparam int TMO_W   = 8;

endpackage

// File: rtl/control_sequencer_ack_timeout.sv
// ack_timeout_counter: counts cycles a memory request waits for its ack.
//   clk_i, rst_ni      - clock and asynchronous active-low reset
//   clear_i            - zero the count (wins over counting)
//   count_en_i         - a memory request is outstanding this cycle
//   ack_i              - memory ack for the outstanding request
//   timeout_cycles_i   - wait limit, 1..255
//   expired_o          - this no-ack cycle brings the count to the limit
module ack_timeout_counter
  import cu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             count_en_i,
  input  logic             ack_i,
  input  logic [TMO_W-1:0] timeout_cycles_i,
  output logic             expired_o
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;
  logic [TMO_W:0]   cnt_inc;

  // One bit wider so the compare cannot alias on wrap.
  assign cnt_inc = {1'b0, cnt_q} + {{TMO_W{1'b0}}, 1'b1};

  // An ack in the same cycle the limit would be reached suppresses expiry.
  assign expired_o = count_en_i & ~ack_i & (cnt_inc == {1'b0, timeout_cycles_i});

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && !ack_i) begin
      cnt_d = cnt_inc[TMO_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute FSM of the CU.
//   Clk, nReset   - clock, asynchronous active-low reset
//   Run           - start pulse, honoured in IDLE or HALT
//   Instruction   - one-hot decode: bit0 Add, bit1 Jump, bit2 Load, bit3 Halt
//   MemAck        - memory completion, only observed in FETCH and LOAD
//   MemReq/MemAddrSel      - memory read request and address select (1 = operand)
//   IRLoad/PCInc/PCLoad    - instruction register and PC strobes
//   AluEn/RegWrite         - ALU add enable and register-file write
//   Halted/Fault/State     - halt flag, sticky fault flag, debug state code
// Build option: define RETIRE_COUNT_EN to add a 16-bit RetireCount output.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Run,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               MemAck,
  output logic               MemReq,
  output logic               MemAddrSel,
  output logic               IRLoad,
  output logic               PCInc,
  output logic               PCLoad,
  output logic               AluEn,
  output logic               RegWrite,
  output logic               Halted,
  output logic               Fault,
  output logic [2:0]         State
`ifdef RETIRE_COUNT_EN
  ,
  output logic [15:0]        RetireCount
`endif
);

  state_t state_q;
  logic   fault_q;
  logic   mem_state;
  logic   ack_take;
  logic   tmo_clear;
  logic   tmo_expired;

  assign mem_state = (state_q == ST_FETCH) || (state_q == ST_LOAD);
  assign ack_take  = mem_state & MemAck;
  // Clearing outside the memory states and on every accepted ack guarantees
  // a zero count on each entry to FETCH or LOAD, including LOAD -> FETCH.
  assign tmo_clear = ~mem_state | ack_take;

  ack_timeout_counter u_tmo (
    .clk_i            (Clk),
    .rst_ni           (nReset),
    .clear_i          (tmo_clear),
    .count_en_i       (mem_state),
    .ack_i            (MemAck),
    .timeout_cycles_i (TMO_W'(TIMEOUT_CYCLES)),
    .expired_o        (tmo_expired)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Run) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (MemAck) begin
            state_q <= ST_DECODE;
          end else if (tmo_expired) begin
            state_q <= ST_HALT;
            fault_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (!$onehot(Instruction)) begin
            state_q <= ST_HALT;
            fault_q <= 1'b1;
          end else if (Instruction[ADD_BIT]) begin
            state_q <= ST_EXEC_ADD;
          end else if (Instruction[JUMP_BIT]) begin
            state_q <= ST_EXEC_JMP;
          end else if (Instruction[LOAD_BIT]) begin
            state_q <= ST_LOAD;
          end else begin
            state_q <= ST_HALT;
          end
        end
        ST_EXEC_ADD: state_q <= ST_FETCH;
        ST_EXEC_JMP: state_q <= ST_FETCH;
        ST_LOAD: begin
          if (MemAck) begin
            state_q <= ST_FETCH;
          end else if (tmo_expired) begin
            state_q <= ST_HALT;
            fault_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (Run) begin
            state_q <= ST_FETCH;
            fault_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore outputs decode from the state register; IRLoad/PCInc and the
  // LOAD-state RegWrite follow MemAck within the ack cycle.
  assign MemReq     = mem_state;
  assign MemAddrSel = (state_q == ST_LOAD);
  assign IRLoad     = (state_q == ST_FETCH) & MemAck;
  assign PCInc      = (state_q == ST_FETCH) & MemAck;
  assign PCLoad     = (state_q == ST_EXEC_JMP);
  assign AluEn      = (state_q == ST_EXEC_ADD);
  assign RegWrite   = (state_q == ST_EXEC_ADD) | ((state_q == ST_LOAD) & MemAck);
  assign Halted     = (state_q == ST_HALT);
  assign Fault      = fault_q;
  assign State      = state_q;

`ifdef RETIRE_COUNT_EN
  logic [15:0] retire_q;
  logic        retire_evt;

  assign retire_evt = (state_q == ST_EXEC_ADD) | (state_q == ST_EXEC_JMP) |
                      ((state_q == ST_LOAD) & MemAck);

  // Free-running retire counter; wraps naturally, untouched by Run.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      retire_q <= '0;
    end else if (retire_evt) begin
      retire_q <= retire_q + 16'd1;
    end
  end

  assign RetireCount = retire_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed bench for control_sequencer (TIMEOUT_CYCLES=4).
// Each row of a stimulus table drives {Run, MemAck, Instruction} for one cycle
// and states the expected outputs
// {MemReq, MemAddrSel, IRLoad, PCInc, PCLoad, AluEn, RegWrite, Halted, Fault, State}.
module tb_control_sequencer;

  logic        Clk;
  logic        nReset;
  logic        Run;
  logic [3:0]  Instruction;
  logic        MemAck;
  logic        MemReq, MemAddrSel, IRLoad, PCInc, PCLoad, AluEn, RegWrite, Halted, Fault;
  logic [2:0]  State;
`ifdef RETIRE_COUNT_EN
  logic [15:0] RetireCount;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_ADD = 3'd3,
                         S_JMP = 3'd4, S_LOAD = 3'd5, S_HALT = 3'd6;

  localparam logic [8:0] O_Z   = 9'b000000000;
  localparam logic [8:0] O_FW  = 9'b100000000;
  localparam logic [8:0] O_FA  = 9'b101100000;
  localparam logic [8:0] O_ADD = 9'b000001100;
  localparam logic [8:0] O_JMP = 9'b000010000;
  localparam logic [8:0] O_LW  = 9'b110000000;
  localparam logic [8:0] O_LA  = 9'b110000100;
  localparam logic [8:0] O_H   = 9'b000000010;
  localparam logic [8:0] O_HF  = 9'b000000011;

  logic [11:0] obs;
  assign obs = {MemReq, MemAddrSel, IRLoad, PCInc, PCLoad, AluEn, RegWrite, Halted, Fault, State};

  control_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .Clk         (Clk),
    .nReset      (nReset),
    .Run         (Run),
    .Instruction (Instruction),
    .MemAck      (MemAck),
    .MemReq      (MemReq),
    .MemAddrSel  (MemAddrSel),
    .IRLoad      (IRLoad),
    .PCInc       (PCInc),
    .PCLoad      (PCLoad),
    .AluEn       (AluEn),
    .RegWrite    (RegWrite),
    .Halted      (Halted),
    .Fault       (Fault),
    .State       (State)
`ifdef RETIRE_COUNT_EN
    ,
    .RetireCount (RetireCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic do_reset();
    @(posedge Clk);
    #3;
    nReset = 1'b0;
    Run = 1'b0;
    MemAck = 1'b0;
    Instruction = 4'b0000;
    #2;
    nReset = 1'b1;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    Run = 1'b1;
    MemAck = 1'b1;
    Instruction = 4'b0001;
    repeat (2) @(posedge Clk);
    #2;
    checks++;
    if (obs !== {O_Z, S_IDLE}) begin
      errors++;
      $display("FAIL reset outputs obs=%b exp=%b", obs, {O_Z, S_IDLE});
    end
`ifdef RETIRE_COUNT_EN
    checks++;
    if (RetireCount !== 16'd0) begin
      errors++;
      $display("FAIL reset retire got=%0d exp=0", RetireCount);
    end
`endif
    Run = 1'b0;
    MemAck = 1'b0;
    Instruction = 4'b0000;
    #1;
    nReset = 1'b1;
  endtask

  // Add with zero-wait ack; MemAck raised in DECODE must be ignored.
  task automatic test_add();
    logic [17:0] v [0:4];
    v = '{ {1'b1, 1'b0, 4'b0000, O_Z,   S_IDLE},
           {1'b0, 1'b1, 4'b0000, O_FA,  S_FETCH},
           {1'b0, 1'b1, 4'b0001, O_Z,   S_DEC},
           {1'b0, 1'b0, 4'b0001, O_ADD, S_ADD},
           {1'b0, 1'b0, 4'b0000, O_FW,  S_FETCH} };
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      {Run, MemAck, Instruction} = v[i][17:12];
      #1;
      checks++;
      if (obs !== v[i][11:0]) begin
        errors++;
        $display("FAIL add cyc%0d obs=%b exp=%b", i, obs, v[i][11:0]);
      end
    end
  endtask

  // Jump with two fetch wait cycles.
  task automatic test_jump();
    logic [17:0] v [0:6];
    v = '{ {1'b1, 1'b0, 4'b0000, O_Z,   S_IDLE},
           {1'b0, 1'b0, 4'b0000, O_FW,  S_FETCH},
           {1'b0, 1'b0, 4'b0000, O_FW,  S_FETCH},
           {1'b0, 1'b1, 4'b0000, O_FA,  S_FETCH},
           {1'b0, 1'b0, 4'b0010, O_Z,   S_DEC},
           {1'b0, 1'b0, 4'b0000, O_JMP, S_JMP},
           {1'b0, 1'b0, 4'b0000, O_FW,  S_FETCH} };
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge Clk); #1;
      {Run, MemAck, Instruction} = v[i][17:12];
      #1;
      checks++;
      if (obs !== v[i][11:0]) begin
        errors++;
        $display("FAIL jump cyc%0d obs=%b exp=%b", i, obs, v[i][11:0]);
      end
    end
  endtask

  // Load with three wait cycles; ack lands as the count would hit the limit.
  task automatic test_load();
    logic [17:0] v [0:7];
    v = '{ {1'b1, 1'b0, 4'b0000, O_Z,  S_IDLE},
           {1'b0, 1'b1, 4'b0000, O_FA, S_FETCH},
           {1'b0, 1'b0, 4'b0100, O_Z,  S_DEC},
           {1'b0, 1'b0, 4'b0000, O_LW, S_LOAD},
           {1'b0, 1'b0, 4'b0000, O_LW, S_LOAD},
           {1'b0, 1'b0, 4'b0000, O_LW, S_LOAD},
           {1'b0, 1'b1, 4'b0000, O_LA, S_LOAD},
           {1'b0, 1'b0, 4'b0000, O_FW, S_FETCH} };
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      {Run, MemAck, Instruction} = v[i][17:12];
      #1;
      checks++;
      if (obs !== v[i][11:0]) begin
        errors++;
        $display("FAIL load cyc%0d obs=%b exp=%b", i, obs, v[i][11:0]);
      end
    end
  endtask

  // Illegal 0110 -> fault + halt; Run restarts and clears the fault;
  // Run while fetching is ignored.
  task automatic test_illegal();
    logic [17:0] v [0:6];
    v = '{ {1'b1, 1'b0, 4'b0000, O_Z,  S_IDLE},
           {1'b0, 1'b1, 4'b0000, O_FA, S_FETCH},
           {1'b0, 1'b0, 4'b0110, O_Z,  S_DEC},
           {1'b0, 1'b0, 4'b0000, O_HF, S_HALT},
           {1'b1, 1'b0, 4'b0000, O_HF, S_HALT},
           {1'b1, 1'b0, 4'b0000, O_FW, S_FETCH},
           {1'b0, 1'b0, 4'b0000, O_FW, S_FETCH} };
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge Clk); #1;
      {Run, MemAck, Instruction} = v[i][17:12];
      #1;
      checks++;
      if (obs !== v[i][11:0]) begin
        errors++;
        $display("FAIL illegal cyc%0d obs=%b exp=%b", i, obs, v[i][11:0]);
      end
    end
  endtask

  // No ack for 4 cycles -> fault; ack in HALT ignored; restart, ack on the
  // 4th fetch cycle wins, then a legal Halt instruction halts without fault.
  task automatic test_timeout();
    logic [17:0] v [0:13];
    v = '{ {1'b1, 1'b0, 4'b0000, O_Z,  S_IDLE},
           {1'b0, 1'b0, 4'b0000, O_FW, S_FETCH},
           {1'b0, 1'b0, 4'b0000, O_FW, S_FETCH},
           {1'b0, 1'b0, 4'b0000, O_FW, S_FETCH},
           {1'b0, 1'b0, 4'b0000, O_FW, S_FETCH},
           {1'b0, 1'b0, 4'b0000, O_HF, S_HALT},
           {1'b0, 1'b1, 4'b0000, O_HF, S_HALT},
           {1'b1, 1'b0, 4'b0000, O_HF, S_HALT},
           {1'b0, 1'b0, 4'b0000, O_FW, S_FETCH},
           {1'b0, 1'b0, 4'b0000, O_FW, S_FETCH},
           {1'b0, 1'b0, 4'b0000, O_FW, S_FETCH},
           {1'b0, 1'b1, 4'b0000, O_FA, S_FETCH},
           {1'b0, 1'b0, 4'b1000, O_Z,  S_DEC},
           {1'b0, 1'b0, 4'b0000, O_H,  S_HALT} };
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(posedge Clk); #1;
      {Run, MemAck, Instruction} = v[i][17:12];
      #1;
      checks++;
      if (obs !== v[i][11:0]) begin
        errors++;
        $display("FAIL timeout cyc%0d obs=%b exp=%b", i, obs, v[i][11:0]);
      end
    end
  endtask

  // Three Adds and a Halt, then restart into LOAD and pull reset mid-request.
  task automatic test_retire_reset();
    logic [17:0] v [0:16];
    v = '{ {1'b1, 1'b0, 4'b0000, O_Z,   S_IDLE},
           {1'b0, 1'b1, 4'b0000, O_FA,  S_FETCH},
           {1'b0, 1'b0, 4'b0001, O_Z,   S_DEC},
           {1'b0, 1'b0, 4'b0000, O_ADD, S_ADD},
           {1'b0, 1'b1, 4'b0000, O_FA,  S_FETCH},
           {1'b0, 1'b0, 4'b0001, O_Z,   S_DEC},
           {1'b0, 1'b0, 4'b0000, O_ADD, S_ADD},
           {1'b0, 1'b1, 4'b0000, O_FA,  S_FETCH},
           {1'b0, 1'b0, 4'b0001, O_Z,   S_DEC},
           {1'b0, 1'b0, 4'b0000, O_ADD, S_ADD},
           {1'b0, 1'b1, 4'b0000, O_FA,  S_FETCH},
           {1'b0, 1'b0, 4'b1000, O_Z,   S_DEC},
           {1'b0, 1'b0, 4'b0000, O_H,   S_HALT},
           {1'b1, 1'b0, 4'b0000, O_H,   S_HALT},
           {1'b0, 1'b1, 4'b0000, O_FA,  S_FETCH},
           {1'b0, 1'b0, 4'b0100, O_Z,   S_DEC},
           {1'b0, 1'b0, 4'b0000, O_LW,  S_LOAD} };
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(posedge Clk); #1;
      {Run, MemAck, Instruction} = v[i][17:12];
      #1;
      checks++;
      if (obs !== v[i][11:0]) begin
        errors++;
        $display("FAIL retire cyc%0d obs=%b exp=%b", i, obs, v[i][11:0]);
      end
    end
`ifdef RETIRE_COUNT_EN
    checks++;
    if (RetireCount !== 16'd3) begin
      errors++;
      $display("FAIL retire count got=%0d exp=3", RetireCount);
    end
`endif
    // Mid-LOAD reset with the ack present: everything must drop at once.
    MemAck = 1'b1;
    #1;
    nReset = 1'b0;
    #1;
    checks++;
    if (obs !== {O_Z, S_IDLE}) begin
      errors++;
      $display("FAIL midload reset obs=%b exp=%b", obs, {O_Z, S_IDLE});
    end
`ifdef RETIRE_COUNT_EN
    checks++;
    if (RetireCount !== 16'd0) begin
      errors++;
      $display("FAIL midload retire got=%0d exp=0", RetireCount);
    end
`endif
    MemAck = 1'b0;
    #1;
    nReset = 1'b1;
  endtask

  initial begin
    nReset = 1'b0;
    Run = 1'b0;
    MemAck = 1'b0;
    Instruction = 4'b0000;
    test_reset();
    test_add();
    test_jump();
    test_load();
    test_illegal();
    test_timeout();
    test_retire_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
